// File: rtl/uart_pkg.sv
// Shared state encoding and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TIMEOUT_CYC = 16384;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search begins one past the last grant and wraps.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [$clog2(N_REQ)-1:0] o_grant,
  output logic                     o_valid
);

  localparam int GW = $clog2(N_REQ);

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    // i == N_REQ revisits the last winner, so it only wins when alone.
    for (int i = 1; i <= N_REQ; i++) begin
      automatic int idx = (int'(i_last) + i) % N_REQ;
      if (!o_valid && i_req[idx]) begin
        o_grant = GW'(idx);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding N_REQ byte sources into one UART transmitter.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [8*N_REQ-1:0]       i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_start_tx,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic [1:0]               o_state,
  output logic                     o_timeout
);

  localparam int GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  state_e           r_state;
  logic             r_start_tx;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_tx_data;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_last;
  logic             r_timeout;

  logic [GW-1:0]    w_win;
  logic             w_any;
  logic [7:0]       w_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_grant (w_win),
    .o_valid (w_any)
  );

  assign w_data = i_data[8*w_win +: 8];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_start_tx <= 1'b0;
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_grant    <= '0;
      r_last     <= GW'(N_REQ - 1);
      r_timeout  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_start_tx <= 1'b0;
      r_ack      <= '0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Start pulse and ack are registered so they coincide with START.
          if (w_any && !i_tx_busy) begin
            r_state    <= ST_START;
            r_grant    <= w_win;
            r_tx_data  <= w_data;
            r_start_tx <= 1'b1;
            r_ack      <= N_REQ'(1) << w_win;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_state   <= ST_IDLE;
            r_last    <= r_grant;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_start_tx = r_start_tx;
  assign o_ack      = r_ack;
  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: expected grants queued at stimulus, checked at o_start_tx.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [N-1:0]   i_req = '0;
  logic [8*N-1:0] i_data = '0;
  logic [N-1:0]   o_ack;
  logic           o_start_tx;
  logic [7:0]     o_tx_data;
  logic           i_tx_busy = 1'b0;
  logic           i_tx_done = 1'b0;
  logic           o_busy;
  logic [1:0]     o_grant_id;
  logic [1:0]     o_state;
  logic           o_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int id; logic [7:0] data; } exp_t;
  exp_t q[$];

  uart_tx_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_start_tx (o_start_tx),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_grant_id (o_grant_id),
    .o_state    (o_state),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every start pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_start_tx === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_start grant=%0d data=%h", o_grant_id, o_tx_data);
      end else begin
        automatic exp_t e = q.pop_front();
        automatic logic [N-1:0] oh = N'(1) << e.id;
        if (o_grant_id !== 2'(e.id) || o_tx_data !== e.data || o_ack !== oh) begin
          n_fail++;
          $display("FAIL sb_grant got id=%0d data=%h ack=%b exp id=%0d data=%h ack=%b",
                   o_grant_id, o_tx_data, o_ack, e.id, e.data, oh);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); i_rst = 1'b1; i_req = '0; i_tx_done = 1'b0; i_tx_busy = 1'b0;
    @(negedge clk); i_rst = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (o_start_tx === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL wait_start timed out, state=%0d", o_state);
    end
  endtask

  task automatic finish_frame(input int gap);
    repeat (gap) @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); i_rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_state !== 2'd0 || o_start_tx !== 1'b0 || o_ack !== '0 || o_tx_data !== 8'h00 ||
        o_grant_id !== 2'd0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values state=%0d start=%b ack=%b data=%h gid=%0d to=%b busy=%b",
               o_state, o_start_tx, o_ack, o_tx_data, o_grant_id, o_timeout, o_busy);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    i_data[8*2 +: 8] = 8'hAB;
    i_req = 4'b0100;
    q.push_back('{2, 8'hAB});
    @(negedge clk);
    n_tests++;
    if (o_start_tx !== 1'b1 || o_state !== 2'd1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency start=%b state=%0d busy=%b exp 1/1/1", o_start_tx, o_state, o_busy);
    end
    i_req = '0;
    @(negedge clk);
    n_tests++;
    if (o_start_tx !== 1'b0 || o_ack !== '0 || o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_start_len start=%b ack=%b state=%0d exp 0/0000/2", o_start_tx, o_ack, o_state);
    end
    finish_frame(4);
    n_tests++;
    if (o_state !== 2'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_back_idle state=%0d busy=%b exp 0/0", o_state, o_busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N; k++) i_data[8*k +: 8] = 8'h10 + 8'(k);
    i_req = 4'b1111;
    for (int f = 0; f < 8; f++) q.push_back('{f % N, 8'h10 + 8'(f % N)});
    for (int f = 0; f < 8; f++) begin
      wait_start();
      finish_frame(10);
      n_tests++;
      if (o_state !== 2'd0) begin
        n_fail++;
        $display("FAIL rr_idle_gap frame=%0d state=%0d exp 0", f, o_state);
      end
    end
    i_req = '0;
    @(negedge clk);
  endtask

  task automatic test_busy_block();
    int bad = 0;
    do_reset();
    i_tx_busy = 1'b1;
    i_data[7:0] = 8'h5A;
    i_req = 4'b0001;
    repeat (20) begin
      @(negedge clk);
      if (o_start_tx !== 1'b0 || o_state !== 2'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_blocks bad_cycles=%0d exp 0", bad);
    end
    i_tx_busy = 1'b0;
    q.push_back('{0, 8'h5A});
    @(negedge clk);
    n_tests++;
    if (o_start_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_release start=%b exp 1", o_start_tx);
    end
    i_req = '0;
    finish_frame(3);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    i_data[8*1 +: 8] = 8'h33;
    i_req = 4'b0010;
    q.push_back('{1, 8'h33});
    wait_start();
    i_req = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    n_tests++;
    if (o_state !== 2'd0 || o_busy !== 1'b0 || o_tx_data !== 8'h00 || o_grant_id !== 2'd0 ||
        o_ack !== '0 || o_start_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid state=%0d busy=%b data=%h gid=%0d ack=%b start=%b exp all zero",
               o_state, o_busy, o_tx_data, o_grant_id, o_ack, o_start_tx);
    end
    i_data[8*3 +: 8] = 8'hC3;
    i_req = 4'b1000;
    q.push_back('{3, 8'hC3});
    wait_start();
    i_req = '0;
    finish_frame(5);
    // last grant is now 3, so requester 0 wins over 1 on a tie
    i_data[7:0] = 8'h01;
    i_req = 4'b0011;
    q.push_back('{0, 8'h01});
    wait_start();
    i_req = '0;
    finish_frame(2);
  endtask

  task automatic test_done_ignored_and_drop();
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    n_tests++;
    if (o_state !== 2'd0 || o_busy !== 1'b0 || o_start_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle state=%0d busy=%b start=%b exp 0/0/0", o_state, o_busy, o_start_tx);
    end
    i_data[8*2 +: 8] = 8'h77;
    i_req = 4'b0100;
    q.push_back('{2, 8'h77});
    wait_start();
    i_tx_done = 1'b1;
    i_req = '0;
    i_data[8*2 +: 8] = 8'hEE;
    @(negedge clk);
    i_tx_done = 1'b0;
    n_tests++;
    if (o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL done_in_start state=%0d exp 2", o_state);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (o_tx_data !== 8'h77 || o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL drop_stable data=%h state=%0d exp 77/2", o_tx_data, o_state);
    end
    finish_frame(1);
    n_tests++;
    if (o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL drop_complete state=%0d exp 0", o_state);
    end
    @(negedge clk);
    n_tests++;
    if (o_start_tx !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_no_regrant start=%b timeout=%b exp 0/0", o_start_tx, o_timeout);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    bit hit = 1'b0;
    do_reset();
    i_data[7:0] = 8'h01;
    i_data[15:8] = 8'h02;
    i_req = 4'b0011;
    q.push_back('{0, 8'h01});
    wait_start();
    i_req = 4'b0010;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      cyc++;
      if (o_timeout === 1'b1) hit = 1'b1;
    end
    n_tests++;
    if (!hit || cyc != TO + 1 || o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_pulse hit=%b cycles=%0d state=%0d exp 1/%0d/0", hit, cyc, o_state, TO + 1);
    end
    q.push_back('{1, 8'h02});
    wait_start();
    i_req = '0;
    finish_frame(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_block();
    test_reset_mid_frame();
    test_done_ignored_and_drop();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover pending=%0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
